// File: rtl/usb_fe_capture.sv
// usb_fe_capture -- USB sniffer front end.
// Turns PHY receive activity into DATA / STAT / TIME records. Each record
// carries a time delta, which is the number of cycles since the previous
// record. Small deltas fit in the short field of the record itself. A large
// delta first emits a TIME record, and the event waits one cycle in a hold
// register.
// Optional feature: define USB_FE_STAT_RECORDS_EN to emit STAT records when
// the {linestate, rxerror, rxactive, rxvalid} vector changes.
module usb_fe_capture #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             I_arm,
  input  logic                             I_timestamps_disable,
  input  logic [15:0]                      I_capture_len,
  input  logic                             I_fifo_full,
  input  logic [7:0]                       I_usb_data,
  input  logic                             I_usb_rxvalid,
  input  logic                             I_usb_rxactive,
  input  logic                             I_usb_rxerror,
  input  logic [1:0]                       I_usb_linestate,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fe_capture_time,
  output logic [7:0]                       O_fe_capture_data,
  output logic [4:0]                       O_fe_capture_stat,
  output logic [1:0]                       O_fe_capture_cmd,
  output logic                             O_fe_capture_data_wr,
  output logic                             O_capture_done
);

  localparam int TW = pTIMESTAMP_FULL_WIDTH;
  localparam logic [TW-1:0] DELTA_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] SHORT_MAX = TW'((64'd1 << pTIMESTAMP_SHORT_WIDTH) - 64'd1);
  localparam logic [TW-1:0] ONE_T     = TW'(1'b1);
  localparam logic [TW-1:0] ZERO_T    = {TW{1'b0}};

  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_STAT = 2'd1;
  localparam logic [1:0] CMD_TIME = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  delta_q, delta_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [4:0]     stat_ref_q, stat_ref_d;
  logic           hold_vld_q, hold_vld_d;
  logic [1:0]     hold_cmd_q, hold_cmd_d;
  logic [7:0]     hold_data_q, hold_data_d;
  logic [4:0]     hold_stat_q, hold_stat_d;
  logic [TW-1:0]  time_q, time_d;
  logic [7:0]     data_q, data_d;
  logic [4:0]     stat_q, stat_d;
  logic [1:0]     cmd_q, cmd_d;
  logic           wr_q, wr_d;

  logic [4:0]     stat_now_s;
  logic           in_capture_s;
  logic           data_ev_s;
  logic           stat_ev_s;
  logic           event_s;
  logic [1:0]     ev_cmd_s;
  logic [7:0]     ev_data_s;
  logic           data_emit_s;
  logic           last_data_s;
  logic           unused_s;

  assign stat_now_s   = {I_usb_linestate, I_usb_rxerror, I_usb_rxactive, I_usb_rxvalid};
  assign in_capture_s = (state_q == ST_CAPTURE);
  assign data_ev_s    = in_capture_s & I_usb_rxactive & I_usb_rxvalid;

`ifdef USB_FE_STAT_RECORDS_EN
  assign stat_ev_s = in_capture_s & (stat_now_s != stat_ref_q) & ~data_ev_s;
  // FIFO full only matters to the downstream drop accounting.
  assign unused_s  = I_fifo_full;
`else
  assign stat_ev_s = 1'b0;
  // FIFO full only matters downstream. The stat reference is still tracked,
  // so both builds keep the same state.
  assign unused_s  = ^{I_fifo_full, stat_ref_q};
`endif

  assign event_s   = data_ev_s | stat_ev_s;
  assign ev_cmd_s  = data_ev_s ? CMD_DATA : CMD_STAT;
  assign ev_data_s = data_ev_s ? I_usb_data : 8'h00;

  assign data_emit_s = wr_d & (cmd_d == CMD_DATA);
  assign last_data_s = data_emit_s & (I_capture_len != 16'd0) &
                       ((cnt_q + 16'd1) == I_capture_len);

  // Next-state logic: a low arm always returns to IDLE; the last requested DATA ends capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (I_arm) state_d = ST_CAPTURE;
        else       state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (!I_arm)           state_d = ST_IDLE;
        else if (last_data_s) state_d = ST_DONE;
        else                  state_d = ST_CAPTURE;
      end
      ST_DONE: begin
        if (!I_arm) state_d = ST_IDLE;
        else        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Record selection: held record first, then a new event, then the saturation TIME record.
  always_comb begin
    delta_d     = delta_q;
    stat_ref_d  = stat_now_s;
    hold_vld_d  = hold_vld_q;
    hold_cmd_d  = hold_cmd_q;
    hold_data_d = hold_data_q;
    hold_stat_d = hold_stat_q;
    wr_d        = 1'b0;
    time_d      = ZERO_T;
    data_d      = 8'h00;
    stat_d      = 5'd0;
    cmd_d       = CMD_DATA;
    if (!I_arm) begin
      // Disarm drops any held record and emits nothing.
      hold_vld_d = 1'b0;
      delta_d    = ZERO_T;
    end else if (state_q == ST_IDLE) begin
      // Arming: start from a clean reference.
      hold_vld_d = 1'b0;
      delta_d    = ZERO_T;
      stat_ref_d = 5'd0;
    end else if (hold_vld_q) begin
      // The held record goes out now. A new event takes its place, so
      // back-to-back events are never lost.
      wr_d    = 1'b1;
      cmd_d   = hold_cmd_q;
      data_d  = hold_data_q;
      stat_d  = hold_stat_q;
      time_d  = I_timestamps_disable ? ZERO_T : ONE_T;
      delta_d = ZERO_T;
      if (event_s) begin
        hold_vld_d  = 1'b1;
        hold_cmd_d  = ev_cmd_s;
        hold_data_d = ev_data_s;
        hold_stat_d = stat_now_s;
      end else begin
        hold_vld_d = 1'b0;
      end
    end else if (event_s) begin
      wr_d    = 1'b1;
      delta_d = ZERO_T;
      if (I_timestamps_disable || (delta_q <= SHORT_MAX)) begin
        cmd_d  = ev_cmd_s;
        data_d = ev_data_s;
        stat_d = stat_now_s;
        time_d = I_timestamps_disable ? ZERO_T : delta_q;
      end else begin
        // The delta does not fit the short field: send it as a TIME record
        // and park the event in the hold register.
        cmd_d       = CMD_TIME;
        time_d      = delta_q;
        hold_vld_d  = 1'b1;
        hold_cmd_d  = ev_cmd_s;
        hold_data_d = ev_data_s;
        hold_stat_d = stat_now_s;
      end
    end else if (in_capture_s && !I_timestamps_disable && (delta_q == DELTA_MAX)) begin
      wr_d    = 1'b1;
      cmd_d   = CMD_TIME;
      time_d  = DELTA_MAX;
      delta_d = ZERO_T;
    end else begin
      delta_d = (delta_q == DELTA_MAX) ? DELTA_MAX : (delta_q + ONE_T);
    end
  end

  // DATA record counter: cleared on arm/disarm, counts every emitted DATA record.
  always_comb begin
    if (!I_arm || (state_q == ST_IDLE)) begin
      cnt_d = 16'd0;
    end else if (data_emit_s) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counters, hold register and registered record outputs.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      delta_q     <= ZERO_T;
      cnt_q       <= 16'd0;
      stat_ref_q  <= 5'd0;
      hold_vld_q  <= 1'b0;
      hold_cmd_q  <= 2'd0;
      hold_data_q <= 8'h00;
      hold_stat_q <= 5'd0;
      time_q      <= ZERO_T;
      data_q      <= 8'h00;
      stat_q      <= 5'd0;
      cmd_q       <= 2'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      delta_q     <= delta_d;
      cnt_q       <= cnt_d;
      stat_ref_q  <= stat_ref_d;
      hold_vld_q  <= hold_vld_d;
      hold_cmd_q  <= hold_cmd_d;
      hold_data_q <= hold_data_d;
      hold_stat_q <= hold_stat_d;
      time_q      <= time_d;
      data_q      <= data_d;
      stat_q      <= stat_d;
      cmd_q       <= cmd_d;
      wr_q        <= wr_d;
    end
  end

  assign O_fe_capture_time    = time_q;
  assign O_fe_capture_data    = data_q;
  assign O_fe_capture_stat    = stat_q;
  assign O_fe_capture_cmd     = cmd_q;
  assign O_fe_capture_data_wr = wr_q;
  assign O_capture_done       = (state_q == ST_DONE);

endmodule

// File: doc/usb_fe_capture.md
USB_FE_CAPTURE -- requirements
Module: usb_fe_capture

Interface
REQ-001 Parameter pTIMESTAMP_FULL_WIDTH, default 16, SHALL set the width of the full time delta field.
REQ-002 Parameter pTIMESTAMP_SHORT_WIDTH, default 3, SHALL set the width of the short time delta carried by DATA and STAT records.
REQ-003 fe_clk  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset_i  in  1  SHALL be a synchronous, active-high reset.
REQ-005 I_arm  in  1  capture enable; synchronous to fe_clk (synchronization is done outside this block).
REQ-006 I_timestamps_disable  in  1  suppresses timing information.
REQ-007 I_capture_len  in  16  number of DATA records to capture; 0 = unlimited.
REQ-008 I_fifo_full  in  1  downstream FIFO full; informational only.
REQ-009 I_usb_data  in  8  sniffed USB byte.
REQ-010 I_usb_rxvalid, I_usb_rxactive, I_usb_rxerror  in  1 each  PHY receive flags.
REQ-011 I_usb_linestate  in  2  PHY line state.
REQ-012 O_fe_capture_time  out  pTIMESTAMP_FULL_WIDTH  record time delta.
REQ-013 O_fe_capture_data  out  8  record data byte.
REQ-014 O_fe_capture_stat  out  5  {linestate[1:0], rxerror, rxactive, rxvalid}.
REQ-015 O_fe_capture_cmd  out  2  record type: DATA=0, STAT=1, TIME=2.
REQ-016 O_fe_capture_data_wr  out  1  one-cycle strobe qualifying a record.
REQ-017 O_capture_done  out  1  high while in the DONE state.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE and DONE:
- IDLE->CAPTURE on the cycle I_arm is first sampled high.
- CAPTURE->DONE on emission of DATA record number I_capture_len (I_capture_len != 0).
- CAPTURE or DONE->IDLE whenever I_arm is low.
REQ-019 On IDLE->CAPTURE the delta counter, the DATA count and the stat-change reference SHALL clear to 0.
REQ-020 A DATA event SHALL be a cycle in CAPTURE with I_usb_rxactive & I_usb_rxvalid.
REQ-021 A STAT event SHALL be a cycle in CAPTURE where the 5-bit stat vector differs from its previous-cycle value and no DATA event occurs; DATA takes precedence.
REQ-022 The delta counter SHALL count fe_clk cycles since the last emitted record, reset to 0 on every emission, and saturate at 2^pTIMESTAMP_FULL_WIDTH-1.
REQ-023 A DATA or STAT event with delta <= 2^pTIMESTAMP_SHORT_WIDTH-1 SHALL be emitted on the next cycle (latency 1), with time = delta in the low pTIMESTAMP_SHORT_WIDTH bits and zeros above.
REQ-024 A DATA or STAT event with a larger delta SHALL instead emit a TIME record carrying the full delta; the event SHALL be held in a one-entry hold register and emitted on the following cycle with time 1.
REQ-025 While the hold register is occupied, a new event SHALL queue behind it: the held record is emitted, the new event enters the hold register, and no event is lost at one event per cycle.
REQ-026 When the delta counter reaches its saturation value with no pending event, a TIME record carrying that value SHALL be emitted and the counter SHALL restart.
REQ-027 A STAT record SHALL carry data = 0x00; a TIME record SHALL carry data and stat = 0.
REQ-028 With I_timestamps_disable high:
- TIME records SHALL NOT be generated.
- The time field SHALL be 0.
- Every event SHALL take the latency-1 path.
REQ-029 The DATA count SHALL increment on each emitted DATA record, including records emitted while I_fifo_full is high; the downstream stage logs the resulting drops.
REQ-030 No record SHALL be emitted in IDLE or DONE, except that a record already in the hold register at the CAPTURE->DONE transition SHALL still be emitted.
REQ-031 A record in the hold register SHALL be discarded when I_arm falls.

Reset
REQ-032 With reset_i high, the FSM SHALL enter IDLE, the hold register SHALL empty, and all counters SHALL clear.
REQ-033 Every output SHALL be 0 on the cycle after reset_i is sampled high, including when reset arrives mid-capture.

Configuration
REQ-034 With USB_FE_STAT_RECORDS_EN defined, STAT events SHALL be generated per REQ-021.
REQ-035 Without USB_FE_STAT_RECORDS_EN, no STAT records SHALL be emitted; stat SHALL still be carried on DATA records and all other behaviour SHALL be unchanged.

Verification
REQ-036 Arm, len=3, 5 back-to-back data bytes 0x11..0x15 with delta <= 7 -> exactly 3 DATA records (0x11..0x13), then O_capture_done=1.
REQ-037 Byte 0x5A arrives 20 cycles after the previous record -> TIME record with time=20, then DATA 0x5A with time=1 on the next cycle.
REQ-038 Same 20-cycle gap followed by 4 back-to-back bytes -> TIME, then 4 DATA records on consecutive cycles with none lost.
REQ-039 Armed and idle for 65535 cycles -> one TIME record with time=0xFFFF.
REQ-040 linestate 01->10 with rxactive low, macro defined -> STAT record with stat=5'b10000; macro undefined -> no record.
REQ-041 reset_i asserted mid-capture while a record is held -> next cycle all outputs 0, and no held record is emitted after reset.
